// File: rtl/pipe_stage_skid.sv
// Pipeline stage with a main register and a one-entry skid register.
// in_ready is registered so upstream never sees a combinational path from
// out_ready; the skid slot absorbs the one entry that may arrive in the
// cycle where the downstream stalls.
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both 1. A producer holding valid=1 keeps its payload stable until ready is
// seen; out_ctrl/out_data stay stable while out_valid=1 and out_ready=0.
module pipe_stage_skid #(
  parameter int CTRL_W = 10,
  parameter int DATA_W = 133,
  parameter int CNT_W  = 16
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stall_cnt
);

  // The state encoding equals the number of held entries, so occupancy is
  // also the externally visible view of the FSM state.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t             state;
  logic               m_valid;
  logic [CTRL_W-1:0]  m_ctrl;
  logic [DATA_W-1:0]  m_data;
  logic               s_valid;
  logic [CTRL_W-1:0]  s_ctrl;
  logic [DATA_W-1:0]  s_data;
  logic               in_ready_q;

  logic accept;
  logic pop;

  assign accept    = in_valid & in_ready_q;
  assign pop       = m_valid & out_ready;

  assign in_ready  = in_ready_q;
  assign out_valid = m_valid;
  assign out_data  = m_data;
  assign out_ctrl  = m_valid ? m_ctrl : '0;
  assign occupancy = state;

  // FSM and entry registers; reset beats flush, flush beats handshakes.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      state      <= EMPTY;
      m_valid    <= 1'b0;
      m_ctrl     <= '0;
      m_data     <= '0;
      s_valid    <= 1'b0;
      s_ctrl     <= '0;
      s_data     <= '0;
      in_ready_q <= 1'b1;
    end else if (flush) begin
      // Data fields are left as they are; only valid and ctrl are cleared.
      state      <= EMPTY;
      m_valid    <= 1'b0;
      m_ctrl     <= '0;
      s_valid    <= 1'b0;
      s_ctrl     <= '0;
      in_ready_q <= 1'b1;
    end else begin
      case (state)
        EMPTY: begin
          if (accept) begin
            m_valid <= 1'b1;
            m_ctrl  <= in_ctrl;
            m_data  <= in_data;
            state   <= ONE;
          end
        end
        ONE: begin
          if (accept && pop) begin
            m_ctrl <= in_ctrl;
            m_data <= in_data;
          end else if (accept) begin
            // Downstream stalled: park the new entry in the skid slot.
            s_valid    <= 1'b1;
            s_ctrl     <= in_ctrl;
            s_data     <= in_data;
            in_ready_q <= 1'b0;
            state      <= TWO;
          end else if (pop) begin
            m_valid <= 1'b0;
            m_ctrl  <= '0;
            state   <= EMPTY;
          end
        end
        TWO: begin
          if (pop) begin
            m_valid    <= s_valid;
            m_ctrl     <= s_ctrl;
            m_data     <= s_data;
            s_valid    <= 1'b0;
            s_ctrl     <= '0;
            in_ready_q <= 1'b1;
            state      <= ONE;
          end
        end
        default: begin
          state      <= EMPTY;
          m_valid    <= 1'b0;
          m_ctrl     <= '0;
          s_valid    <= 1'b0;
          s_ctrl     <= '0;
          in_ready_q <= 1'b1;
        end
      endcase
    end
  end

  // Saturating count of edges where an entry is presented but not taken.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      stall_cnt <= '0;
    end else if (m_valid && !out_ready && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Bench for pipe_stage_skid: a queue model of the held entries is checked
// against the DUT on every falling edge, plus literal checks of key points.
module tb_pipe_stage_skid;

  localparam int CTRL_W = 10;
  localparam int DATA_W = 133;
  localparam int CNT_W  = 4;
  localparam int CMAX   = (1 << CNT_W) - 1;
  localparam int W      = CTRL_W + DATA_W;

  logic              clock;
  logic              resetn;
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [CTRL_W-1:0] in_ctrl;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [CTRL_W-1:0] out_ctrl;
  logic [DATA_W-1:0] out_data;
  logic [1:0]        occupancy;
  logic [CNT_W-1:0]  stall_cnt;

  int checks = 0;
  int errors = 0;
  logic check_en = 1'b0;

  // Model state: held entries in order, stall count, post-reset data flag.
  logic [W-1:0] exp_q[$];
  int           m_cnt = 0;
  logic         zero_data = 1'b1;

  pipe_stage_skid #(.CTRL_W(CTRL_W), .DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clock     (clock),
    .resetn    (resetn),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_ctrl   (in_ctrl),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_ctrl  (out_ctrl),
    .out_data  (out_data),
    .occupancy (occupancy),
    .stall_cnt (stall_cnt)
  );

  // Clock and reset-related block.
  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [DATA_W-1:0] mk_data(input int v);
    logic [DATA_W-1:0] d;
    d = DATA_W'(v);
    return (d << 100) | d;
  endfunction

  // Model update: a stage holding up to two entries in arrival order.
  always @(posedge clock) begin
    logic acc;
    if (!resetn) begin
      exp_q.delete();
      m_cnt = 0;
      zero_data = 1'b1;
    end else begin
      if (exp_q.size() > 0 && !out_ready && m_cnt < CMAX) m_cnt++;
      if (flush) begin
        exp_q.delete();
      end else begin
        acc = in_valid && (exp_q.size() < 2);
        if (exp_q.size() > 0 && out_ready) void'(exp_q.pop_front());
        if (acc) begin
          exp_q.push_back({in_ctrl, in_data});
          zero_data = 1'b0;
        end
      end
    end
  end

  // Scoreboard compare on every falling edge.
  always @(negedge clock) begin
    logic [W-1:0] head;
    if (check_en) begin
      check("occupancy", 256'(occupancy), 256'(exp_q.size()));
      check("in_ready", 256'(in_ready), 256'(exp_q.size() < 2));
      check("out_valid", 256'(out_valid), 256'(exp_q.size() > 0));
      check("stall_cnt", 256'(stall_cnt), 256'(m_cnt));
      if (exp_q.size() > 0) begin
        head = exp_q[0];
        check("out_ctrl", 256'(out_ctrl), 256'(head[W-1:DATA_W]));
        check("out_data", 256'(out_data), 256'(head[DATA_W-1:0]));
      end else begin
        check("out_ctrl_idle", 256'(out_ctrl), 256'(0));
        if (zero_data) check("out_data_reset", 256'(out_data), 256'(0));
      end
    end
  end

  // Driver: apply one cycle of inputs at a falling edge, return at the next.
  task automatic cyc(input logic iv, input int c, input int d, input logic ordy, input logic fl);
    in_valid  = iv;
    in_ctrl   = CTRL_W'(c);
    in_data   = mk_data(d);
    out_ready = ordy;
    flush     = fl;
    @(negedge clock);
  endtask

  initial begin
    resetn = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_ctrl = '0; in_data = '0;
    @(negedge clock);
    @(negedge clock);
    check_en = 1'b1;
    check("rst_in_ready", 256'(in_ready), 256'(1));
    check("rst_out_valid", 256'(out_valid), 256'(0));
    check("rst_out_data", 256'(out_data), 256'(0));
    check("rst_occupancy", 256'(occupancy), 256'(0));
    check("rst_stall", 256'(stall_cnt), 256'(0));
    resetn = 1'b1;

    // Streaming 1..6
    for (int i = 1; i <= 6; i++) cyc(1'b1, i + 16, i, 1'b1, 1'b0);
    check("stream_data", 256'(out_data), 256'(mk_data(6)));
    check("stream_occ", 256'(occupancy), 256'(1));
    check("stream_stall", 256'(stall_cnt), 256'(0));

    // Bubble mid-stream
    cyc(1'b1, 23, 7, 1'b1, 1'b0);
    cyc(1'b0, 0, 0, 1'b1, 1'b0);
    check("bubble_valid", 256'(out_valid), 256'(0));
    check("bubble_ctrl", 256'(out_ctrl), 256'(0));
    cyc(1'b1, 24, 8, 1'b1, 1'b0);
    check("bubble_next", 256'(out_data), 256'(mk_data(8)));
    cyc(1'b0, 0, 0, 1'b1, 1'b0);

    // Backpressure: A then B while stalled
    cyc(1'b1, 10, 'hA, 1'b0, 1'b0);
    cyc(1'b1, 11, 'hB, 1'b0, 1'b0);
    check("bp_occ", 256'(occupancy), 256'(2));
    check("bp_in_ready", 256'(in_ready), 256'(0));
    check("bp_data_a", 256'(out_data), 256'(mk_data('hA)));
    cyc(1'b0, 0, 0, 1'b0, 1'b0);
    cyc(1'b0, 0, 0, 1'b0, 1'b0);
    check("bp_stall", 256'(stall_cnt), 256'(3));
    check("bp_hold_a", 256'(out_data), 256'(mk_data('hA)));
    cyc(1'b0, 0, 0, 1'b1, 1'b0);
    check("bp_data_b", 256'(out_data), 256'(mk_data('hB)));
    check("bp_ctrl_b", 256'(out_ctrl), 256'(11));
    cyc(1'b0, 0, 0, 1'b1, 1'b0);
    check("bp_drained", 256'(occupancy), 256'(0));

    // Flush in TWO with a same-cycle input
    cyc(1'b1, 12, 'hC, 1'b0, 1'b0);
    cyc(1'b1, 13, 'hD, 1'b0, 1'b0);
    cyc(1'b1, 14, 'h77, 1'b0, 1'b1);
    check("fl_valid", 256'(out_valid), 256'(0));
    check("fl_ctrl", 256'(out_ctrl), 256'(0));
    check("fl_in_ready", 256'(in_ready), 256'(1));
    check("fl_occ", 256'(occupancy), 256'(0));
    check("fl_stall", 256'(stall_cnt), 256'(5));
    cyc(1'b0, 0, 0, 1'b1, 1'b0);
    check("fl_no_emit", 256'(out_valid), 256'(0));

    // Stall counter saturation
    cyc(1'b1, 15, 'hE, 1'b0, 1'b0);
    repeat (20) cyc(1'b0, 0, 0, 1'b0, 1'b0);
    check("sat_stall", 256'(stall_cnt), 256'(15));
    check("sat_hold", 256'(out_data), 256'(mk_data('hE)));

    // Reset while in TWO
    cyc(1'b1, 16, 'hF, 1'b0, 1'b0);
    check("pre_rst_occ", 256'(occupancy), 256'(2));
    resetn = 1'b0;
    cyc(1'b1, 17, 'h10, 1'b1, 1'b0);
    check("mrst_valid", 256'(out_valid), 256'(0));
    check("mrst_ctrl", 256'(out_ctrl), 256'(0));
    check("mrst_data", 256'(out_data), 256'(0));
    check("mrst_in_ready", 256'(in_ready), 256'(1));
    check("mrst_stall", 256'(stall_cnt), 256'(0));
    resetn = 1'b1;
    cyc(1'b1, 3, 5, 1'b1, 1'b0);
    check("post_rst_data", 256'(out_data), 256'(mk_data(5)));
    check("post_rst_valid", 256'(out_valid), 256'(1));

    // Mixed traffic checked by the model
    for (int i = 0; i < 300; i++) begin
      cyc(1'($urandom_range(0, 1)), int'($urandom_range(1, 1023)), int'($urandom),
          1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 31) == 0));
    end
    cyc(1'b0, 0, 0, 1'b1, 1'b0);
    cyc(1'b0, 0, 0, 1'b1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
